psm_idxcnt_nd: RTL and testbench
================================

# psm_idxcnt_nd

Parametrised partial-sum-manager index counter with N nested counter levels and N saved counter contexts. It generates SRAM word addresses, per-element read/write masks, a write-FIFO pop strobe and done flags for the PSM datapath. It sits between the PSM controller and the partial-sum SRAM port. It generalises the fixed four-level, dual-context counter to NLVL levels and NCTX contexts, with a selectable done level and a single-sum address.

## Interface
- IDX_W, 11, width of every counter index, limit and step
- WOFS_W, 3, word-offset bits; SRAMC_N must equal 2**WOFS_W
- ADRC_W, 8, SRAM address width
- SRAMC_N, 8, elements per SRAM word
- NLVL, 4, nested counter levels (2..8); level 0 is innermost
- NCTX, 2, saved counter contexts (1..4); CTX_W = max(1, $clog2(NCTX))
---
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_cnt_en  in  1  advance counters / pipeline enable
- i_cnt_clear  in  1  zero the selected context and pipeline
- i_start  in  1  first position of a new pass
- i_wr_flag  in  1  current pass is a write pass
- i_ctx_sel  in  CTX_W  active context
- i_lim  in  NLVL*IDX_W  per-level limit, level j at [j*IDX_W +: IDX_W]
- i_step  in  NLVL*IDX_W  per-level step, same packing
- i_done_lvl  in  3  highest level included in o_done
- o_mask  out  [0:SRAMC_N-1]  active elements of the current word
- o_wr_fifo_pop  out  1  pop strobe to write buffer
- o_sram_addr  out  ADRC_W  SRAM word address
- o_done  out  1  levels 0..i_done_lvl all at last value
- o_til_done  out  1  all levels at last value

## Operation
- Each level has NCTX index registers. Only bank i_ctx_sel reads and updates; other banks hold.
- ov[j] = (idx[j] + step[j] >= lim[j]). The compare is IDX_W+1 bits wide, so it has no overflow.
- Level 0 advances when i_cnt_en. Level j advances when i_cnt_en and ov[0..j-1] all set.
- On advance, a counter takes idx+step, or 0 when ov is set.
- When i_cnt_en=0, counters hold. Disable does not clear them.
- i_cnt_clear zeroes only the selected context's indices and has priority over advance.
- S = sum of all idx[j], width IDX_W+$clog2(NLVL).
- addr = S>>WOFS_W, truncated to ADRC_W.
- woffs = S[WOFS_W-1:0].
- word_base = addr<<WOFS_W, computed before truncation.
- row_start = S − idx[0]; idx_end = row_start + lim[0] − 1.
- lo = S when first-of-row (transition register set, or i_start); otherwise lo = word_base.
- The transition register holds ov[0]&i_cnt_en from the previous enabled cycle.
- mask[i] = (word_base+i >= lo) && (word_base+i <= idx_end). The mask is all zero when word_base > idx_end.
- Pop is pre-registered as the transition register & i_wr_flag.
- Done is pre-registered as AND of ov[0..i_done_lvl]. An i_done_lvl value >= NLVL is clamped to NLVL−1.
- Til-done is pre-registered as AND of all ov.

## Timing
- i_rst: all context banks, the transition register and all pipeline registers go to 0. All outputs are 0 from the next edge.
- Reset mid-pass discards the pass.
- Stage 1 register: addr, mask, done, til-done, captured at an edge with i_cnt_en=1 and i_cnt_clear=0. o_sram_addr is valid 1 cycle after the counter state.
- Stage 1 registers clear to 0 at any edge where i_cnt_en=0 or i_cnt_clear=1.
- o_done = done_q & i_cnt_en; o_til_done = til_done_q & i_cnt_en. These are combinationally gated by i_cnt_en.
- o_mask = 0 when (i_cnt_en=0 and done not pending) or (i_start and i_wr_flag).
- A context switch takes effect on the same cycle. In-flight pipeline data belongs to the old context.
- Simultaneous i_cnt_clear and i_start: clear wins, and the start mask is computed from zeroed indices.

## Configuration
- PSM_IDXCNT_ND_OUTSHIM_EN defined: mask, done, til-done and pop pass through a second register stage (latency 2), which aligns them with the SRAM read pipeline. o_sram_addr stays at latency 1. The second stage uses the same clear rules as stage 1.
- Not defined: mask, done, til-done and pop are taken from stage 1 (latency 1).

## Test plan
- Aligned sweep: NLVL=2, SRAMC_N=8, lim={16,32}, step={8,16}, i_done_lvl=0, 4 enabled cycles. Required response: o_sram_addr 0,1,2,3; every mask 11111111; o_done on positions 2 and 4; o_til_done only on position 4.
- Unaligned row: idx[1]=3 fixed, lim0=10, step0=8. Required response: position 1 at addr 0 with mask 00011111; position 2 at addr 1 with mask 11111000.
- Context switch: run ctx0 for 3 steps, ctx1 for 2 steps, then return to ctx0. Required response: ctx0 resumes at its 4th position; ctx1 indices are unaffected by ctx0.
- Stall: drop i_cnt_en for 3 cycles mid-row. Required response: indices hold, o_mask=0 and o_done=0 while stalled, and the sequence resumes with no position lost.
- Write pop: i_wr_flag=1, lim0=16, step0=8. Required response: o_wr_fifo_pop pulses once per row, on the position after the wrap, at configured latency.
- Reset/clear: assert i_rst mid-pass. Required response: all outputs 0 the next cycle and restart from addr 0. Assert i_cnt_clear with i_ctx_sel=1. Required response: ctx0 indices retained.

Source files
------------

// File: rtl/psm_idxcnt_nd.sv
// psm_idxcnt_nd: N-level, N-context index counter for the PSM SRAM port.
// Define PSM_IDXCNT_ND_OUTSHIM_EN to add a second output register stage.
module psm_idxcnt_nd #(
    parameter int IDX_W   = 11,
    parameter int WOFS_W  = 3,
    parameter int ADRC_W  = 8,
    parameter int SRAMC_N = 8,
    parameter int NLVL    = 4,
    parameter int NCTX    = 2,
    parameter int CTX_W   = (NCTX > 1) ? $clog2(NCTX) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_cnt_en,
    input  logic                    i_cnt_clear,
    input  logic                    i_start,
    input  logic                    i_wr_flag,
    input  logic [CTX_W-1:0]        i_ctx_sel,
    input  logic [NLVL*IDX_W-1:0]   i_lim,
    input  logic [NLVL*IDX_W-1:0]   i_step,
    input  logic [2:0]              i_done_lvl,
    output logic [0:SRAMC_N-1]      o_mask,
    output logic                    o_wr_fifo_pop,
    output logic [ADRC_W-1:0]       o_sram_addr,
    output logic                    o_done,
    output logic                    o_til_done
);

    localparam int SUM_W = IDX_W + $clog2(NLVL);
    localparam int CMP_W = SUM_W + 2;

    logic [IDX_W-1:0]   r_idx [NCTX][NLVL];
    logic               r_trans;

    logic [IDX_W-1:0]   w_idx  [NLVL];
    logic [IDX_W-1:0]   w_lim  [NLVL];
    logic [IDX_W-1:0]   w_step [NLVL];
    logic [IDX_W-1:0]   w_nxt  [NLVL];
    logic [NLVL-1:0]    w_ov;
    logic [NLVL-1:0]    w_adv;

    logic [SUM_W-1:0]   w_sum;
    logic [ADRC_W-1:0]  w_addr;
    logic [CMP_W-1:0]   w_base;
    logic [CMP_W-1:0]   w_lo;
    logic [CMP_W-1:0]   w_row;
    logic [CMP_W-1:0]   w_end_x;
    logic [0:SRAMC_N-1] w_mask;
    logic [2:0]         w_dlvl;
    logic               w_done;
    logic               w_til;
    logic               w_pop;

    // Clear zeroes the view too, so a same-cycle start sees zeroed indices.
    always_comb begin
        w_adv = '0;
        w_ov  = '0;
        for (int j = 0; j < NLVL; j++) begin
            w_lim[j]  = i_lim[j*IDX_W +: IDX_W];
            w_step[j] = i_step[j*IDX_W +: IDX_W];
            w_idx[j]  = i_cnt_clear ? '0 : r_idx[i_ctx_sel][j];
            w_ov[j]   = ({1'b0, w_idx[j]} + {1'b0, w_step[j]})
                        >= {1'b0, w_lim[j]};
            w_nxt[j]  = w_ov[j] ? '0 : w_idx[j] + w_step[j];
        end
        w_adv[0] = i_cnt_en;
        for (int j = 1; j < NLVL; j++) begin
            w_adv[j] = w_adv[j-1] & w_ov[j-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < NCTX; c++) begin
                for (int j = 0; j < NLVL; j++) begin
                    r_idx[c][j] <= '0;
                end
            end
        end else if (i_cnt_clear) begin
            for (int j = 0; j < NLVL; j++) begin
                r_idx[i_ctx_sel][j] <= '0;
            end
        end else begin
            for (int j = 0; j < NLVL; j++) begin
                if (w_adv[j]) begin
                    r_idx[i_ctx_sel][j] <= w_nxt[j];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clear) begin
            r_trans <= 1'b0;
        end else if (i_cnt_en) begin
            r_trans <= w_ov[0];
        end
    end

    // Row end is kept exclusive so a zero limit yields an empty mask.
    always_comb begin
        w_sum = '0;
        for (int j = 0; j < NLVL; j++) begin
            w_sum = w_sum + SUM_W'(w_idx[j]);
        end
        w_addr  = ADRC_W'(w_sum >> WOFS_W);
        w_base  = CMP_W'({w_sum[SUM_W-1:WOFS_W], {WOFS_W{1'b0}}});
        w_lo    = (r_trans | i_start) ? CMP_W'(w_sum) : w_base;
        w_row   = CMP_W'(w_sum) - CMP_W'(w_idx[0]);
        w_end_x = w_row + CMP_W'(w_lim[0]);
        w_mask  = '0;
        for (int i = 0; i < SRAMC_N; i++) begin
            w_mask[i] = ((w_base + CMP_W'(i)) >= w_lo) &&
                        ((w_base + CMP_W'(i)) <  w_end_x);
        end
    end

    always_comb begin
        w_dlvl = (int'(i_done_lvl) >= NLVL) ? 3'(NLVL - 1) : i_done_lvl;
        w_done = 1'b1;
        for (int j = 0; j < NLVL; j++) begin
            if (j <= int'(w_dlvl)) begin
                w_done = w_done & w_ov[j];
            end
        end
        w_til = &w_ov;
        w_pop = r_trans & i_wr_flag;
    end

    logic [ADRC_W-1:0]  r1_addr;
    logic [0:SRAMC_N-1] r1_mask;
    logic               r1_done;
    logic               r1_til;
    logic               r1_pop;

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_cnt_en || i_cnt_clear) begin
            r1_addr <= '0;
            r1_mask <= '0;
            r1_done <= 1'b0;
            r1_til  <= 1'b0;
            r1_pop  <= 1'b0;
        end else begin
            r1_addr <= w_addr;
            r1_mask <= w_mask;
            r1_done <= w_done;
            r1_til  <= w_til;
            r1_pop  <= w_pop;
        end
    end

    logic [0:SRAMC_N-1] w_mask_q;
    logic               w_done_q;
    logic               w_til_q;
    logic               w_pop_q;

`ifdef PSM_IDXCNT_ND_OUTSHIM_EN
    logic [0:SRAMC_N-1] r2_mask;
    logic               r2_done;
    logic               r2_til;
    logic               r2_pop;

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_cnt_en || i_cnt_clear) begin
            r2_mask <= '0;
            r2_done <= 1'b0;
            r2_til  <= 1'b0;
            r2_pop  <= 1'b0;
        end else begin
            r2_mask <= r1_mask;
            r2_done <= r1_done;
            r2_til  <= r1_til;
            r2_pop  <= r1_pop;
        end
    end

    assign w_mask_q = r2_mask;
    assign w_done_q = r2_done;
    assign w_til_q  = r2_til;
    assign w_pop_q  = r2_pop;
`else
    assign w_mask_q = r1_mask;
    assign w_done_q = r1_done;
    assign w_til_q  = r1_til;
    assign w_pop_q  = r1_pop;
`endif

    assign o_sram_addr   = r1_addr;
    assign o_done        = w_done_q & i_cnt_en;
    assign o_til_done    = w_til_q & i_cnt_en;
    assign o_wr_fifo_pop = w_pop_q;
    assign o_mask = ((!i_cnt_en && !w_done_q) || (i_start && i_wr_flag))
                    ? '0 : w_mask_q;

endmodule

// File: tb/tb_psm_idxcnt_nd.sv
// Directed bench for psm_idxcnt_nd with default parameters.
// Levels 2 and 3 are pinned at 0 (lim=1, step=1) so they always overflow.
module tb_psm_idxcnt_nd;

`ifdef PSM_IDXCNT_ND_OUTSHIM_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, en, clr, start, wr;
    logic [0:0]  ctx;
    logic [43:0] lim, stp;
    logic [2:0]  dlvl;
    logic [0:7]  mask;
    logic        pop, done, til;
    logic [7:0]  addr;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] cap_addr [16];
    logic [0:7] cap_mask [16];
    logic       cap_done [16];
    logic       cap_til  [16];
    logic       cap_pop  [16];

    psm_idxcnt_nd dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cnt_en      (en),
        .i_cnt_clear   (clr),
        .i_start       (start),
        .i_wr_flag     (wr),
        .i_ctx_sel     (ctx),
        .i_lim         (lim),
        .i_step        (stp),
        .i_done_lvl    (dlvl),
        .o_mask        (mask),
        .o_wr_fifo_pop (pop),
        .o_sram_addr   (addr),
        .o_done        (done),
        .o_til_done    (til)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int l0, input int s0, input int l1, input int s1);
        lim = {11'd1, 11'd1, 11'(l1), 11'(l0)};
        stp = {11'd1, 11'd1, 11'(s1), 11'(s0)};
    endtask

    task automatic run(input int n);
        en = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            cap_addr[i] = addr;
            cap_mask[i] = mask;
            cap_done[i] = done;
            cap_til[i]  = til;
            cap_pop[i]  = pop;
            start = 1'b0;
        end
        en = 1'b0;
    endtask

    task automatic do_clear(input logic c);
        ctx = c;
        clr = 1'b1;
        en  = 1'b0;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        en = 1'b1;
        step();
        n_chk += 5;
        if (addr !== 8'd0) begin
            n_err++; $display("FAIL reset_addr got %0d want 0", addr);
        end
        if (mask !== 8'h00) begin
            n_err++; $display("FAIL reset_mask got %b want 00000000", mask);
        end
        if (done !== 1'b0) begin
            n_err++; $display("FAIL reset_done got %b want 0", done);
        end
        if (til !== 1'b0) begin
            n_err++; $display("FAIL reset_til got %b want 0", til);
        end
        if (pop !== 1'b0) begin
            n_err++; $display("FAIL reset_pop got %b want 0", pop);
        end
        rst = 1'b0;
        en  = 1'b0;
    endtask

    task automatic test_aligned();
        logic [7:0] ea [4] = '{8'd0, 8'd1, 8'd2, 8'd3};
        logic       ed [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic       et [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_clear(1'b0);
        cfg(16, 8, 32, 16);
        dlvl  = 3'd0;
        start = 1'b1;
        run(5);
        for (int k = 0; k < 4; k++) begin
            n_chk += 4;
            if (cap_addr[k] !== ea[k]) begin
                n_err++;
                $display("FAIL aligned_addr[%0d] got %0d want %0d",
                         k, cap_addr[k], ea[k]);
            end
            if (cap_mask[k+LAT-1] !== 8'hff) begin
                n_err++;
                $display("FAIL aligned_mask[%0d] got %b want 11111111",
                         k, cap_mask[k+LAT-1]);
            end
            if (cap_done[k+LAT-1] !== ed[k]) begin
                n_err++;
                $display("FAIL aligned_done[%0d] got %b want %b",
                         k, cap_done[k+LAT-1], ed[k]);
            end
            if (cap_til[k+LAT-1] !== et[k]) begin
                n_err++;
                $display("FAIL aligned_til[%0d] got %b want %b",
                         k, cap_til[k+LAT-1], et[k]);
            end
        end
    endtask

    task automatic test_done_clamp();
        logic ed [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_clear(1'b0);
        cfg(16, 8, 32, 16);
        dlvl = 3'd7;
        run(5);
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (cap_done[k+LAT-1] !== ed[k]) begin
                n_err++;
                $display("FAIL clamp_done[%0d] got %b want %b",
                         k, cap_done[k+LAT-1], ed[k]);
            end
        end
        dlvl = 3'd0;
    endtask

    task automatic test_unaligned();
        logic [7:0] ea [3] = '{8'd0, 8'd1, 8'd0};
        logic [0:7] em [3] = '{8'b00011111, 8'b11111000, 8'b00000011};
        do_clear(1'b0);
        cfg(1, 1, 16, 3);
        run(1);
        cfg(10, 8, 16, 3);
        start = 1'b1;
        run(4);
        for (int k = 0; k < 3; k++) begin
            n_chk += 2;
            if (cap_addr[k] !== ea[k]) begin
                n_err++;
                $display("FAIL unaligned_addr[%0d] got %0d want %0d",
                         k, cap_addr[k], ea[k]);
            end
            if (cap_mask[k+LAT-1] !== em[k]) begin
                n_err++;
                $display("FAIL unaligned_mask[%0d] got %b want %b",
                         k, cap_mask[k+LAT-1], em[k]);
            end
        end
    endtask

    task automatic test_ctx_switch();
        do_clear(1'b0);
        do_clear(1'b1);
        cfg(16, 8, 32, 16);
        ctx = 1'b0;
        run(3);
        ctx = 1'b1;
        run(2);
        n_chk += 2;
        if (cap_addr[0] !== 8'd0) begin
            n_err++; $display("FAIL ctx1_first got %0d want 0", cap_addr[0]);
        end
        if (cap_addr[1] !== 8'd1) begin
            n_err++; $display("FAIL ctx1_second got %0d want 1", cap_addr[1]);
        end
        ctx = 1'b0;
        run(1);
        n_chk++;
        if (cap_addr[0] !== 8'd3) begin
            n_err++; $display("FAIL ctx0_resume got %0d want 3", cap_addr[0]);
        end
        ctx = 1'b1;
        run(1);
        n_chk++;
        if (cap_addr[0] !== 8'd2) begin
            n_err++; $display("FAIL ctx1_resume got %0d want 2", cap_addr[0]);
        end
    endtask

    task automatic test_stall();
        do_clear(1'b0);
        cfg(16, 8, 32, 16);
        run(2);
        n_chk += 2;
        if (cap_addr[0] !== 8'd0 || cap_addr[1] !== 8'd1) begin
            n_err++;
            $display("FAIL stall_pre got %0d,%0d want 0,1",
                     cap_addr[0], cap_addr[1]);
        end
        if (cap_done[LAT-1] !== 1'b0) begin
            n_err++; $display("FAIL stall_pre_done got %b want 0", cap_done[LAT-1]);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_chk += 2;
            if (mask !== 8'h00) begin
                n_err++;
                $display("FAIL stall_mask[%0d] got %b want 00000000", k, mask);
            end
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL stall_done[%0d] got %b want 0", k, done);
            end
        end
        run(2);
        n_chk += 2;
        if (cap_addr[0] !== 8'd2) begin
            n_err++; $display("FAIL stall_resume0 got %0d want 2", cap_addr[0]);
        end
        if (cap_addr[1] !== 8'd3) begin
            n_err++; $display("FAIL stall_resume1 got %0d want 3", cap_addr[1]);
        end
    endtask

    task automatic test_write_pop();
        logic ep [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_clear(1'b0);
        cfg(16, 8, 32, 16);
        wr = 1'b1;
        run(6);
        for (int k = 0; k < 5; k++) begin
            n_chk++;
            if (cap_pop[k+LAT-1] !== ep[k]) begin
                n_err++;
                $display("FAIL pop[%0d] got %b want %b",
                         k, cap_pop[k+LAT-1], ep[k]);
            end
        end
        do_clear(1'b0);
        start = 1'b1;
        en    = 1'b1;
        step();
        n_chk++;
        if (mask !== 8'h00) begin
            n_err++; $display("FAIL wr_start_mask got %b want 00000000", mask);
        end
        en    = 1'b0;
        start = 1'b0;
        wr    = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_clear(1'b0);
        cfg(16, 8, 32, 16);
        run(3);
        rst = 1'b1;
        en  = 1'b1;
        step();
        n_chk += 4;
        if (addr !== 8'd0) begin
            n_err++; $display("FAIL rstmid_addr got %0d want 0", addr);
        end
        if (mask !== 8'h00) begin
            n_err++; $display("FAIL rstmid_mask got %b want 00000000", mask);
        end
        if (done !== 1'b0 || til !== 1'b0) begin
            n_err++; $display("FAIL rstmid_done got %b%b want 00", done, til);
        end
        if (pop !== 1'b0) begin
            n_err++; $display("FAIL rstmid_pop got %b want 0", pop);
        end
        rst = 1'b0;
        en  = 1'b0;
        run(2);
        n_chk += 2;
        if (cap_addr[0] !== 8'd0) begin
            n_err++; $display("FAIL rstmid_restart got %0d want 0", cap_addr[0]);
        end
        if (cap_addr[1] !== 8'd1) begin
            n_err++; $display("FAIL rstmid_next got %0d want 1", cap_addr[1]);
        end
    endtask

    task automatic test_clear_ctx();
        do_clear(1'b0);
        do_clear(1'b1);
        cfg(16, 8, 32, 16);
        ctx = 1'b0;
        run(3);
        ctx = 1'b1;
        run(1);
        do_clear(1'b1);
        ctx = 1'b0;
        run(1);
        n_chk++;
        if (cap_addr[0] !== 8'd3) begin
            n_err++; $display("FAIL clr_ctx0_kept got %0d want 3", cap_addr[0]);
        end
        ctx = 1'b1;
        run(1);
        n_chk++;
        if (cap_addr[0] !== 8'd0) begin
            n_err++; $display("FAIL clr_ctx1_zero got %0d want 0", cap_addr[0]);
        end
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        clr   = 1'b0;
        start = 1'b0;
        wr    = 1'b0;
        ctx   = 1'b0;
        dlvl  = 3'd0;
        cfg(16, 8, 32, 16);
        test_reset();
        test_aligned();
        test_done_clamp();
        test_unaligned();
        test_ctx_switch();
        test_stall();
        test_write_pop();
        test_reset_mid();
        test_clear_ctx();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
